// File: rtl/change_dispenser_if.sv
// Bundles the request side (vending FSM) and the hopper side of the change
// dispenser. The dispenser is the slave; the FSM/hopper environment is the master.
interface change_dispenser_if #(
    parameter int AMT_W = 6
) ();
    logic             req;
    logic [AMT_W-1:0] amount;
    logic             empty10;
    logic             empty5;
    logic             hopper_ack;
    logic [1:0]       coin_out;
    logic             busy;
    logic             done;
    logic             err;
    logic [AMT_W-1:0] owed;

    modport master (
        output req, amount, empty10, empty5, hopper_ack,
        input  coin_out, busy, done, err, owed
    );

    modport slave (
        input  req, amount, empty10, empty5, hopper_ack,
        output coin_out, busy, done, err, owed
    );
endinterface

// File: rtl/change_dispenser.sv
// Coin-return engine: pays out a rupee amount as 10rs coins first, then 5rs
// coins, one coin at a time over a hold-until-acknowledge hopper handshake.
// Reports completion, faults (reject / empty hopper / ack timeout) and the
// balance left undelivered by the last aborted dispense.
module change_dispenser #(
    parameter int MAX_AMOUNT = 50,
    parameter int AMT_W      = 6,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 16
) (
    input logic               clk,
    input logic               reset,
    change_dispenser_if.slave bus
);

    localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [AMT_W-1:0] MAX_AMT  = AMT_W'(MAX_AMOUNT);
    localparam logic [AMT_W-1:0] FIVE     = AMT_W'(5);
    localparam logic [AMT_W-1:0] TEN      = AMT_W'(10);

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        GAP,
        DONE,
        FAULT
    } state_t;

    state_t             state_q, state_d;
    logic [AMT_W-1:0]   remaining_q, remaining_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [1:0]         coin_out_q, coin_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [AMT_W-1:0]   owed_q, owed_d;
    logic [AMT_W-1:0]   rem_after_ack;
    logic               amount_bad;

    // Next-state, datapath and registered-output decode.
    // Status outputs are derived from the next state so that done/err/busy
    // line up with the state they describe while remaining registered.
    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        gap_cnt_d     = gap_cnt_q;
        to_cnt_d      = to_cnt_q;
        coin_out_d    = coin_out_q;
        owed_d        = owed_q;
        rem_after_ack = remaining_q - ((coin_out_q == COIN_10) ? TEN : FIVE);
        amount_bad    = ((bus.amount % FIVE) != '0) || (bus.amount > MAX_AMT);

        case (state_q)
            IDLE: begin
                coin_out_d = COIN_NONE;
                if (bus.req) begin
                    if (bus.amount == '0) begin
                        owed_d  = '0;
                        state_d = DONE;
                    end else if (amount_bad) begin
                        state_d = FAULT;
                    end else begin
                        remaining_d = bus.amount;
                        owed_d      = '0;
                        state_d     = ISSUE;
                    end
                end
            end

            ISSUE: begin
                if ((remaining_q >= TEN) && !bus.empty10) begin
                    coin_out_d = COIN_10;
                    to_cnt_d   = '0;
                    state_d    = WAIT_ACK;
                end else if (!bus.empty5) begin
                    coin_out_d = COIN_5;
                    to_cnt_d   = '0;
                    state_d    = WAIT_ACK;
                end else begin
                    owed_d  = remaining_q;
                    state_d = FAULT;
                end
            end

            WAIT_ACK: begin
                if (bus.hopper_ack) begin
                    remaining_d = rem_after_ack;
                    coin_out_d  = COIN_NONE;
                    gap_cnt_d   = '0;
                    state_d     = (rem_after_ack == '0) ? DONE : GAP;
                end else if (to_cnt_q == TO_LAST) begin
                    coin_out_d = COIN_NONE;
                    owed_d     = remaining_q;
                    state_d    = FAULT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end

            GAP: begin
                coin_out_d = COIN_NONE;
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ISSUE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            FAULT: begin
                state_d = IDLE;
            end

            default: begin
                coin_out_d = COIN_NONE;
                state_d    = IDLE;
            end
        endcase

        busy_d = (state_d == ISSUE) || (state_d == WAIT_ACK) || (state_d == GAP);
        done_d = (state_d == DONE);
        err_d  = (state_d == FAULT);
    end

    // State and output registers; reset withdraws any presented coin at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            gap_cnt_q   <= '0;
            to_cnt_q    <= '0;
            coin_out_q  <= COIN_NONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            owed_q      <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            gap_cnt_q   <= gap_cnt_d;
            to_cnt_q    <= to_cnt_d;
            coin_out_q  <= coin_out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            owed_q      <= owed_d;
        end
    end

    assign bus.coin_out = coin_out_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.owed     = owed_q;

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-return engine for the vending machine: the outbound counterpart of the `coin` input encoding. It accepts a refund or change request carrying a rupee amount. It then issues coins one at a time to the coin hopper over a hold-until-acknowledge handshake, using 10rs coins first and 5rs coins for the remainder. It sits between the vending FSM (which raises `change` or cancels) and the hopper driver, and reports completion, faults and any undelivered balance.

## Interface

- `MAX_AMOUNT`, default 50: largest legal request in rs; must be a multiple of 5.
- `AMT_W`, default 6: width of amount and balance fields; must hold `MAX_AMOUNT`.
- `GAP_CYCLES`, default 1 (≥1): idle cycles between successive coins.
- `TIMEOUT`, default 16 (≥2): cycles allowed in WAIT_ACK without `hopper_ack` before a fault.

Ports:

- `clk` in 1: the single clock; everything is rising-edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `req` in 1: one-cycle request strobe.
- `amount` in AMT_W: rs to return; sampled only when `req`=1 in IDLE.
- `empty10` in 1: hopper has no 10rs coins.
- `empty5` in 1: hopper has no 5rs coins.
- `hopper_ack` in 1: hopper confirms the presented coin was dropped.
- `coin_out` out 2: 2'b01 = 5rs, 2'b10 = 10rs, 2'b00 = none; 2'b11 is never driven.
- `busy` out 1: a request is in progress.
- `done` out 1: one-cycle pulse when the full amount is delivered.
- `err` out 1: one-cycle pulse on a rejected request or an aborted dispense.
- `owed` out AMT_W: undelivered balance after the last fault.

## Operation

**States:** IDLE, ISSUE, WAIT_ACK, GAP, DONE, FAULT.

**Registers:** `remaining` (AMT_W), gap counter, timeout counter.

**IDLE**
- `busy`=0 and `coin_out`=0.
- On `req`=1:
  - `amount`=0: go to DONE. No coins are issued and `owed` is cleared.
  - `amount` mod 5 ≠ 0, or `amount` > `MAX_AMOUNT`: go to FAULT with `remaining` unchanged and `owed` unchanged.
  - Otherwise: `remaining`←`amount`, `owed`←0, go to ISSUE.

**ISSUE** (one cycle, `busy`=1)
- If `remaining` ≥ 10 and `empty10`=0: register `coin_out`←10.
- Else if `empty5`=0: register `coin_out`←01.
- Else: go to FAULT.
- On a coin choice, clear the timeout counter and go to WAIT_ACK.
- The empty flags are sampled here only. A change while a coin is presented has no effect on that coin.

**WAIT_ACK**
- `coin_out` is held stable.
- On `hopper_ack`=1: `remaining` ← `remaining` − 10 or − 5 (per the coin), `coin_out`←0. Go to DONE if the new `remaining`=0, else to GAP.
- On `hopper_ack`=0: the timeout counter increments. If it reaches `TIMEOUT`−1 with no ack, go to FAULT and set `coin_out`←0.
- `hopper_ack` takes priority over timeout in the same cycle.

**GAP**
- `coin_out`=0 for `GAP_CYCLES` cycles, then go to ISSUE.

**DONE**
- `done`=1 and `busy`=0 for one cycle, then go to IDLE.

**FAULT**
- `err`=1 and `busy`=0 for one cycle.
- `owed`←`remaining` for aborted dispenses; rejected requests leave `owed` unchanged.
- Then go to IDLE.

**General rules**
- `req` outside IDLE is ignored, and is not queued.
- `hopper_ack` outside WAIT_ACK is ignored.
- `remaining` never underflows: the 10rs coin is only chosen when `remaining` ≥ 10, and all legal amounts are multiples of 5.

## Timing

- **Reset:** while `reset`=0, the block is forced immediately, without waiting for a clock edge, to state IDLE with `coin_out`=0, `busy`=0, `done`=0, `err`=0, `owed`=0 and `remaining`=0.
  - This includes reset asserted mid-dispense: the presented coin is withdrawn and the balance is lost.
  - Operation resumes at the first rising edge after `reset` returns to 1.
- **All outputs are registered.**
- **First coin:** `req` sampled at edge k → ISSUE after k → `coin_out` valid after edge k+1.
- **Next coin:** `hopper_ack` sampled at edge m → `coin_out`=0 after m → next coin valid after edge m+`GAP_CYCLES`+1.
- **Completion:** the final ack at edge m gives `done`=1 during the cycle after m, and the block is back in IDLE after m+1.
- **Zero amount:** `done` appears the cycle after `req`.
- **Bad amount:** `err` appears the cycle after `req`.
- **Timeout:** if the coin is presented after edge p and no ack arrives, `err`=1 after edge p+`TIMEOUT`.
- **Handshake:** `coin_out` changes only on entering WAIT_ACK or leaving it. The hopper may hold `hopper_ack` high for one cycle or longer. A held ack causes only one decrement per coin, because the block is in GAP, DONE or FAULT on the following cycle.
- **Cycle-level requirements:**
  - `busy` is 1 exactly from the cycle after an accepted `req` through the last GAP/WAIT_ACK cycle.
  - `done` and `err` are never high together.
  - `done` and `err` never last more than one cycle.

## Test plan

1. **Normal mix:** `amount`=25, empties 0, ack one cycle after each coin → `coin_out` 10, 10, 01 in that order with ≥1 zero cycle between coins; `done` pulses once; `owed`=0. A second `req` raised while `busy`=1 is ignored.
2. **No 10rs coins:** `amount`=20, `empty10`=1 → four 01 coins, then `done`.
3. **Running out of 5s:** `amount`=15, `empty5`=1, `empty10`=0 → one 10 coin, then FAULT: `err`=1, `owed`=5, no 01 coin ever driven.
4. **Rejects and zero:**
   - `amount`=7 → `err` the next cycle, no coin, `owed` unchanged.
   - `amount`=55 → `err`.
   - `amount`=0 → `done` the next cycle with no coin.
5. **Timeout:** `amount`=10, `hopper_ack` held 0 → `coin_out`=10 for exactly 16 cycles, then `coin_out`=0, `err`=1, `owed`=10. Repeat with ack on cycle 16 → delivered, and `done` instead of `err`.
6. **Reset mid-dispense:** `reset`=0 during WAIT_ACK of a 50rs request, between clock edges → `coin_out`, `busy` and `owed` are 0 immediately. After release, a new `req` of 5 dispenses one 01 coin normally.
